qs_partition_ctrl: RTL

//  Sequencer for one Lomuto partition pass of the quick-sort engine over sort RAM region [lo..hi].

---
 rtl/qs_pkg.sv | 24 ++
 rtl/qs_index_counter.sv | 25 ++
 rtl/qs_partition_ctrl.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/qs_pkg.sv
// Shared definitions for the quick-sort partition sequencer.
// Contents: default index/data widths, largest index, partition FSM state type.
package qs_pkg;

    localparam int unsigned QS_AW      = 5;
    localparam int unsigned QS_DW      = 8;
    localparam int unsigned QS_IDX_MAX = (1 << QS_AW) - 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_RD_PIV,
        S_LD_PIV,
        S_RD_J,
        S_CMP_J,
        S_RD_I,
        S_SW_J,
        S_SW_I,
        S_FIN_RD_I,
        S_FIN_WR_HI,
        S_FIN_WR_I,
        S_DONE
    } qs_part_state_t;

endpackage

// File: rtl/qs_index_counter.sv
// AW-bit index register with synchronous load and increment.
// Ports: clk, rst_n (async active-low), load/load_val (load wins over inc),
//        inc (+1), cnt (current value).
module qs_index_counter #(
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (inc) begin
            cnt <= cnt + AW'(1);
        end
    end

endmodule

// File: rtl/qs_partition_ctrl.sv
// Lomuto partition sequencer for one pass over sort RAM region [lo..hi],
// pivot taken from mem[hi]. Drives a single-port RAM with 1-cycle read latency.
// Ports: clk, reset (async active-low), start/lo/hi (request), busy, done,
//        pivot_idx, mem_addr/mem_re/mem_we/mem_wdata/mem_rdata (RAM side).
// Optional build macro QS_SWAP_STATS_EN adds swap_cnt and cmp_cnt outputs.
module qs_partition_ctrl
    import qs_pkg::*;
#(
    parameter int unsigned AW = QS_AW,
    parameter int unsigned DW = QS_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW-1:0] lo,
    input  logic [AW-1:0] hi,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] pivot_idx,
    output logic [AW-1:0] mem_addr,
    output logic          mem_re,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
`ifdef QS_SWAP_STATS_EN
    ,
    output logic [AW:0]   swap_cnt,
    output logic [AW:0]   cmp_cnt
`endif
);

    qs_part_state_t state_q, state_nxt;

    logic [AW-1:0] i_q, j_q, hi_q;
    logic [DW-1:0] pivot_q, vj_q;
    logic          i_ld, j_ld, i_inc, j_inc;
    logic          accept, lt, i_eq_j;
    logic [AW-1:0] i_after, j_after;

    qs_index_counter #(.AW(AW)) u_i (
        .clk(clk), .rst_n(reset), .load(i_ld), .load_val(lo), .inc(i_inc), .cnt(i_q)
    );
    qs_index_counter #(.AW(AW)) u_j (
        .clk(clk), .rst_n(reset), .load(j_ld), .load_val(lo), .inc(j_inc), .cnt(j_q)
    );

    assign accept  = (state_q == S_IDLE) && start;
    assign lt      = mem_rdata < pivot_q;
    assign i_eq_j  = (i_q == j_q);
    assign i_after = i_inc ? i_q + AW'(1) : i_q;
    assign j_after = j_q + AW'(1);

    // pivot_idx tracks i, which is untouched between DONE and the next start.
    assign pivot_idx = i_q;
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            pivot_q <= '0;
            vj_q    <= '0;
        end else begin
            state_q <= state_nxt;
            if (accept)               hi_q    <= hi;
            if (state_q == S_LD_PIV)  pivot_q <= mem_rdata;
            if (state_q == S_CMP_J)   vj_q    <= mem_rdata;
        end
    end

    always_comb begin
        state_nxt = state_q;
        i_ld      = 1'b0;
        j_ld      = 1'b0;
        i_inc     = 1'b0;
        j_inc     = 1'b0;
        mem_addr  = '0;
        mem_re    = 1'b0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    i_ld      = 1'b1;
                    j_ld      = 1'b1;
                    state_nxt = (lo < hi) ? S_RD_PIV : S_DONE;
                end
            end
            S_RD_PIV: begin
                mem_addr  = hi_q;
                mem_re    = 1'b1;
                state_nxt = S_LD_PIV;
            end
            S_LD_PIV: state_nxt = S_RD_J;
            S_RD_J: begin
                mem_addr  = j_q;
                mem_re    = 1'b1;
                state_nxt = S_CMP_J;
            end
            S_CMP_J: begin
                if (lt && !i_eq_j) begin
                    state_nxt = S_RD_I;
                end else begin
                    i_inc = lt;
                    j_inc = 1'b1;
                    // Loop exit decided on post-increment indices; final swap
                    // is skipped when the pivot is already in place.
                    if (j_after != hi_q)      state_nxt = S_RD_J;
                    else if (i_after == hi_q) state_nxt = S_DONE;
                    else                      state_nxt = S_FIN_RD_I;
                end
            end
            S_RD_I: begin
                mem_addr  = i_q;
                mem_re    = 1'b1;
                state_nxt = S_SW_J;
            end
            S_SW_J: begin
                // vi arrives on read data this cycle and is written straight through.
                mem_addr  = j_q;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata;
                state_nxt = S_SW_I;
            end
            S_SW_I: begin
                mem_addr  = i_q;
                mem_we    = 1'b1;
                mem_wdata = vj_q;
                i_inc     = 1'b1;
                j_inc     = 1'b1;
                if (j_after != hi_q)      state_nxt = S_RD_J;
                else if (i_after == hi_q) state_nxt = S_DONE;
                else                      state_nxt = S_FIN_RD_I;
            end
            S_FIN_RD_I: begin
                mem_addr  = i_q;
                mem_re    = 1'b1;
                state_nxt = S_FIN_WR_HI;
            end
            S_FIN_WR_HI: begin
                mem_addr  = hi_q;
                mem_we    = 1'b1;
                mem_wdata = mem_rdata;
                state_nxt = S_FIN_WR_I;
            end
            S_FIN_WR_I: begin
                mem_addr  = i_q;
                mem_we    = 1'b1;
                mem_wdata = pivot_q;
                state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef QS_SWAP_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            swap_cnt <= '0;
            cmp_cnt  <= '0;
        end else if (accept) begin
            swap_cnt <= '0;
            cmp_cnt  <= '0;
        end else begin
            if (state_q == S_SW_I || state_q == S_FIN_WR_I) swap_cnt <= swap_cnt + (AW+1)'(1);
            if (state_q == S_CMP_J)                         cmp_cnt  <= cmp_cnt + (AW+1)'(1);
        end
    end
`endif

endmodule
